// File: rtl/mdu_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer; every add/subtract step is issued
// to an external 32-bit ALU through the alu_* ports, result returned on hi/lo.
module mdu_seq #(
   parameter logic [2:0] ALU_ADD = 3'b000,
   parameter logic [2:0] ALU_SUB = 3'b100,
   parameter int         N_ITER  = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_by_zero,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_ctr,
   input  logic [31:0] alu_result
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

   state_t      state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        dbz_q, dbz_d, done_q, done_d;
   logic        last_iter, accept_mul, accept_div, accept_dz;
   logic        carry, borrow, ok;
   logic [31:0] rs;

   assign accept_mul = start && (state_q == S_IDLE) && (op == 2'b00);
   assign accept_div = start && (state_q == S_IDLE) && (op == 2'b01) && (src_b != 32'd0);
   assign accept_dz  = start && (state_q == S_IDLE) && (op == 2'b01) && (src_b == 32'd0);
   assign last_iter  = (cnt_q == 5'(N_ITER - 1));

   // Divide step works on the partial remainder shifted left by one dividend bit
   assign rs     = {hi_q[30:0], lo_q[31]};
   assign carry  = (alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~alu_result[31]);
   assign borrow = (~alu_a[31] & alu_b[31]) | (~(alu_a[31] ^ alu_b[31]) & alu_result[31]);
   assign ok     = hi_q[31] | ~borrow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_mul)      state_d = S_MUL;
            else if (accept_div) state_d = S_DIV;
            else if (accept_dz)  state_d = S_FIN;
         end
         S_MUL:   if (last_iter) state_d = S_FIN;
         S_DIV:   if (last_iter) state_d = S_FIN;
         default: state_d = S_IDLE;
      endcase
   end

   // ALU operands come only from registered state, never from start/src_*
   always_comb begin
      alu_a   = 32'd0;
      alu_b   = 32'd0;
      alu_ctr = ALU_ADD;
      case (state_q)
         S_MUL: begin
            alu_a = hi_q;
            alu_b = opnd_q;
         end
         S_DIV: begin
            alu_a   = rs;
            alu_b   = opnd_q;
            alu_ctr = ALU_SUB;
         end
         default: ;
      endcase
   end

   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      opnd_d = opnd_q;
      cnt_d  = cnt_q;
      dbz_d  = dbz_q;
      done_d = (state_q == S_FIN);
      case (state_q)
         S_IDLE: begin
            if (accept_mul) begin
               opnd_d = src_a;
               hi_d   = 32'd0;
               lo_d   = src_b;
               cnt_d  = 5'd0;
            end else if (accept_div) begin
               opnd_d = src_b;
               hi_d   = 32'd0;
               lo_d   = src_a;
               cnt_d  = 5'd0;
               dbz_d  = 1'b0;
            end else if (accept_dz) begin
               hi_d  = src_a;
               lo_d  = 32'hFFFF_FFFF;
               dbz_d = 1'b1;
            end
         end
         S_MUL: begin
            if (lo_q[0]) {hi_d, lo_d} = {carry, alu_result, lo_q[31:1]};
            else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
            cnt_d = cnt_q + 5'd1;
         end
         S_DIV: begin
            hi_d  = ok ? alu_result : rs;
            lo_d  = {lo_q[30:0], ok};
            cnt_d = cnt_q + 5'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         opnd_q <= 32'd0;
         cnt_q  <= 5'd0;
         dbz_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         opnd_q <= opnd_d;
         cnt_q  <= cnt_d;
         dbz_q  <= dbz_d;
         done_q <= done_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq with a behavioural 32-bit ALU closing the alu_* loop.
module tb_mdu_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a, src_b;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo, alu_a, alu_b, alu_result;
   logic [2:0]  alu_ctr;

   int n_chk  = 0;
   int n_fail = 0;

   mdu_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
      .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   // External ALU: add for 000, subtract for 100
   always_comb begin
      alu_result = alu_a + alu_b;
      if (alu_ctr == 3'b100) alu_result = alu_a - alu_b;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] ctr_exp, input int inject,
                         output int edges, output int busy_cyc, output int ctr_bad,
                         output logic got_done);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk);
      #1;
      start = 1'b0; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678;
      edges = 1; busy_cyc = 0; ctr_bad = 0; got_done = 1'b0;
      for (int i = 0; i < 100 && !got_done; i++) begin
         @(negedge clk);
         if (done) got_done = 1'b1;
         else begin
            if (busy) busy_cyc++;
            if (busy && busy_cyc <= 32 && alu_ctr !== ctr_exp) ctr_bad++;
            if (inject != 0 && busy_cyc == inject) begin
               start = 1'b1; op = 2'b00; src_a = 32'd1000; src_b = 32'd1000;
            end
            @(posedge clk);
            edges++;
            #1 start = 1'b0;
         end
      end
   endtask

   task automatic full_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [2:0] ctr_exp, input int inject,
                             input int exp_edges, input int exp_busy,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                             input logic exp_dbz);
      int e, bc, cb;
      logic gd;
      run_op(o, a, b, ctr_exp, inject, e, bc, cb, gd);
      chk({tag, " done_seen"}, 64'(gd), 64'(1'b1));
      chk({tag, " edges"}, 64'(e), 64'(exp_edges));
      chk({tag, " busy_cycles"}, 64'(bc), 64'(exp_busy));
      chk({tag, " alu_ctr"}, 64'(cb), 64'd0);
      chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
      chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
      chk({tag, " dbz"}, 64'(div_by_zero), 64'(exp_dbz));
      @(negedge clk);
      chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
      chk({tag, " busy_after"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcount;
      rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0;
      #3;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst hilo", {hi, lo}, 64'd0);
      chk("rst dbz", 64'(div_by_zero), 64'd0);
      chk("rst alu", {29'd0, alu_ctr, alu_a}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      full_check("mul7x6", 2'b00, 32'd7, 32'd6, 3'b000, 0, 34, 33, 32'd0, 32'd42, 1'b0);
      repeat (3) @(negedge clk);
      chk("hold lo", 64'(lo), 64'd42);
      full_check("mulmax", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 0, 34, 33,
                 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      full_check("mulshift", 2'b00, 32'h1234_5678, 32'h10, 3'b000, 0, 34, 33,
                 32'h0000_0001, 32'h2345_6780, 1'b0);
      full_check("div100_7", 2'b01, 32'd100, 32'd7, 3'b100, 0, 34, 33, 32'd2, 32'd14, 1'b0);
      full_check("divmax_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 3'b100, 0, 34, 33,
                 32'd0, 32'hFFFF_FFFF, 1'b0);
      full_check("div8_max", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 0, 34, 33,
                 32'h8000_0000, 32'd0, 1'b0);
      full_check("div5_0", 2'b01, 32'd5, 32'd0, 3'b000, 0, 2, 1, 32'd5, 32'hFFFF_FFFF, 1'b1);
      full_check("div9_3", 2'b01, 32'd9, 32'd3, 3'b100, 0, 34, 33, 32'd0, 32'd3, 1'b0);
      full_check("mul_inject", 2'b00, 32'd7, 32'd6, 3'b000, 10, 34, 33, 32'd0, 32'd42, 1'b0);

      // Reserved op must not start anything
      @(negedge clk);
      start = 1'b1; op = 2'b10; src_a = 32'd4; src_b = 32'd4;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("op10 busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      chk("op10 busy later", 64'(busy), 64'd0);
      chk("op10 lo", 64'(lo), 64'd42);

      // Asynchronous abort partway through a divide
      @(negedge clk);
      start = 1'b1; op = 2'b01; src_a = 32'd1000; src_b = 32'd7;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (15) @(negedge clk);
      chk("abort busy_before", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort done", 64'(done), 64'd0);
      chk("abort hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) dcount++;
      end
      chk("abort no_done", 64'(dcount), 64'd0);
      full_check("mul3x3", 2'b00, 32'd3, 32'd3, 3'b000, 0, 34, 33, 32'd0, 32'd9, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
